// File: rtl/trk_seq_pkg.sv
// Shared types and constants for the GPS L1 tracking correlator sequencer.
package trk_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_REL,
    S_GO,
    S_WAIT,
    S_SEND,
    S_CLR,
    S_STOP
  } seq_state_t;

  localparam logic [1:0] PRM_PHASE_STEP = 2'd0;
  localparam logic [1:0] PRM_REM_PHASE  = 2'd1;
  localparam logic [1:0] PRM_CODE_STEP  = 2'd2;
  localparam logic [1:0] PRM_PHASE_RATE = 2'd3;

  localparam int NUM_PRM      = 4;
  localparam int STREAM_BEATS = 7;

endpackage

// File: rtl/trk_seq_result_ser.sv
// Latches one epoch's header and six accumulators, then plays them out as a
// 7-beat AXI-Stream packet; abort drops the packet without a tlast.
module trk_seq_result_ser
  import trk_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          axis_aclk,
  input  logic          axis_aresetn,
  input  logic          load,
  input  logic          abort,
  input  logic [DW-1:0] hdr,
  input  logic [DW-1:0] i_iE,
  input  logic [DW-1:0] i_qE,
  input  logic [DW-1:0] i_iP,
  input  logic [DW-1:0] i_qP,
  input  logic [DW-1:0] i_iL,
  input  logic [DW-1:0] i_qL,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          done,
  output logic          pending
);

  localparam int BW = $clog2(STREAM_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(STREAM_BEATS - 1);

  logic [DW-1:0] words_q [STREAM_BEATS];
  logic [BW-1:0] beat_q;
  logic          arm_q;
  logic          tvalid_q;
  logic          last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      // NOTE: the word store is reset as well; it is tiny and keeps tdata defined out of reset.
      words_q  <= '{default: '0};
      beat_q   <= '0;
      arm_q    <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (abort) begin
      beat_q   <= '0;
      arm_q    <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (load) begin
      words_q[0] <= hdr;
      words_q[1] <= i_iE;
      words_q[2] <= i_qE;
      words_q[3] <= i_iP;
      words_q[4] <= i_qP;
      words_q[5] <= i_iL;
      words_q[6] <= i_qL;
      beat_q     <= '0;
      arm_q      <= 1'b1;
      tvalid_q   <= 1'b0;
    end else if (arm_q) begin
      // First beat is presented one cycle after the latch.
      arm_q    <= 1'b0;
      tvalid_q <= 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      if (last_beat) begin
        tvalid_q <= 1'b0;
        beat_q   <= '0;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign m_axis_tdata  = words_q[beat_q];
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & last_beat;
  assign done          = tvalid_q & m_axis_tready & last_beat;
  assign pending       = tvalid_q | arm_q;

endmodule

// File: rtl/trk_corr_sequencer_gps_l1.sv
// Epoch sequencer for the GPS L1 tracking correlator with double-buffered NCO/code
// parameters. Define TRK_SEQ_TIMEOUT_EN to add a watchdog on the ready wait.
module trk_corr_sequencer_gps_l1
  import trk_seq_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DROP_CYC    = 16,
  parameter int EPOCH_W     = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               axis_aclk,
  input  logic               axis_aresetn,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [EPOCH_W-1:0] i_num_epochs,
  input  logic               i_prm_wr,
  input  logic [1:0]         i_prm_addr,
  input  logic [DW-1:0]      i_prm_data,
  input  logic               i_prm_commit,
  output logic               o_drop_samples,
  output logic               o_drop_samples_valid,
  output logic               o_go,
  output logic               o_start_tracking_valid,
  output logic               o_clear_accum,
  output logic               o_stop_tracking,
  output logic               o_stop_tracking_valid,
  output logic [DW-1:0]      o_phase_step_rad,
  output logic [DW-1:0]      o_rem_carr_phase_rad,
  output logic [DW-1:0]      o_code_phase_step_chips,
  output logic [DW-1:0]      o_phase_step_rate_rad,
  input  logic               i_corr_ready,
  input  logic [DW-1:0]      i_iE,
  input  logic [DW-1:0]      i_qE,
  input  logic [DW-1:0]      i_iP,
  input  logic [DW-1:0]      i_qP,
  input  logic [DW-1:0]      i_iL,
  input  logic [DW-1:0]      i_qL,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic               o_busy,
  output logic               o_err
);

  localparam int DCW = $clog2(DROP_CYC + 1);

  seq_state_t         state_q, state_d;
  logic [DCW-1:0]     drop_cnt_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [EPOCH_W-1:0] epoch_inc;
  logic               err_q;
  logic               ready_q;
  logic               commit_q;
  logic [DW-1:0]      shadow_q [NUM_PRM];
  logic [DW-1:0]      active_q [NUM_PRM];
  logic               ready_edge;
  logic               stop_req;
  logic               start_acc;
  logic               ser_load;
  logic               ser_done;
  logic               ser_pending;
  logic               timeout;

  assign epoch_inc  = epoch_q + 1'b1;
  assign ready_edge = i_corr_ready & ~ready_q;
  assign start_acc  = (state_q == S_IDLE) && i_start;
  // STOP is already on its way to IDLE; re-entering it would double the stop pulse.
  assign stop_req   = i_stop && (state_q != S_IDLE) && (state_q != S_STOP);
  assign ser_load   = (state_q == S_WAIT) && ready_edge && !stop_req;

`ifdef TRK_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wdog_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn)                  wdog_q <= '0;
    else if (state_q != S_WAIT)         wdog_q <= '0;
    else if (wdog_q != TW'(TIMEOUT_CYC)) wdog_q <= wdog_q + 1'b1;
  end

  assign timeout = (state_q == S_WAIT) && (wdog_q == TW'(TIMEOUT_CYC));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    // NOTE: state_d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_DROP;
      S_DROP: if (drop_cnt_q == DCW'(DROP_CYC - 1)) state_d = S_REL;
      S_REL:  state_d = S_GO;
      S_GO:   state_d = S_WAIT;
      S_WAIT: begin
        if (ready_edge)   state_d = S_SEND;
        else if (timeout) state_d = S_STOP;
      end
      S_SEND: begin
        if (ser_done)
          state_d = ((i_num_epochs != '0) && (epoch_inc == i_num_epochs)) ? S_STOP : S_CLR;
      end
      S_CLR:  state_d = S_GO;
      S_STOP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop_req) state_d = S_STOP;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= S_IDLE;
      drop_cnt_q <= '0;
      epoch_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      commit_q   <= 1'b0;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ready_q    <= i_corr_ready;
      drop_cnt_q <= (state_q == S_DROP) ? drop_cnt_q + 1'b1 : '0;

      if (start_acc)
        epoch_q <= '0;
      else if ((state_q == S_SEND) && ser_done && !stop_req)
        epoch_q <= epoch_inc;

      if (start_acc)
        err_q <= 1'b0;
      else if ((stop_req && ser_pending) || (timeout && !ready_edge))
        err_q <= 1'b1;

      if (i_prm_wr) shadow_q[i_prm_addr] <= i_prm_data;

      // A commit seen during CLR stays pending for the next boundary.
      if (i_prm_commit)          commit_q <= 1'b1;
      else if (state_q == S_CLR) commit_q <= 1'b0;

      if (start_acc || ((state_q == S_CLR) && commit_q)) active_q <= shadow_q;
    end
  end

  trk_seq_result_ser #(.DW(DW)) u_ser (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .load         (ser_load),
    .abort        (stop_req),
    .hdr          (DW'(epoch_q)),
    .i_iE         (i_iE),
    .i_qE         (i_qE),
    .i_iP         (i_iP),
    .i_qP         (i_qP),
    .i_iL         (i_iL),
    .i_qL         (i_qL),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .done         (ser_done),
    .pending      (ser_pending)
  );

  assign o_drop_samples          = (state_q == S_DROP);
  assign o_drop_samples_valid    = (state_q == S_DROP) && (drop_cnt_q == '0);
  assign o_go                    = (state_q == S_GO);
  assign o_start_tracking_valid  = (state_q == S_GO);
  assign o_clear_accum           = (state_q == S_CLR);
  assign o_stop_tracking         = (state_q == S_STOP);
  assign o_stop_tracking_valid   = (state_q == S_STOP);
  assign o_phase_step_rad        = active_q[PRM_PHASE_STEP];
  assign o_rem_carr_phase_rad    = active_q[PRM_REM_PHASE];
  assign o_code_phase_step_chips = active_q[PRM_CODE_STEP];
  assign o_phase_step_rate_rad   = active_q[PRM_PHASE_RATE];
  assign o_epoch                 = epoch_q;
  assign o_busy                  = (state_q != S_IDLE);
  assign o_err                   = err_q;

endmodule

// File: tb/tb_trk_corr_sequencer_gps_l1.sv
// Directed bench for trk_corr_sequencer_gps_l1: parameter table, nominal run,
// stale ready, backpressure, mid-stream stop and (with TRK_SEQ_TIMEOUT_EN) watchdog.
module tb_trk_corr_sequencer_gps_l1;

  localparam int DW = 32, DROP_CYC = 16, EPOCH_W = 16, TIMEOUT_CYC = 50;

  logic axis_aclk = 0, axis_aresetn = 0;
  logic i_start = 0, i_stop = 0, i_prm_wr = 0, i_prm_commit = 0;
  logic [EPOCH_W-1:0] i_num_epochs = '0;
  logic [1:0] i_prm_addr = '0;
  logic [DW-1:0] i_prm_data = '0;
  logic i_corr_ready, m_axis_tready;
  logic [DW-1:0] i_iE, i_qE, i_iP, i_qP, i_iL, i_qL;
  logic o_drop_samples, o_drop_samples_valid, o_go, o_start_tracking_valid;
  logic o_clear_accum, o_stop_tracking, o_stop_tracking_valid;
  logic [DW-1:0] o_phase_step_rad, o_rem_carr_phase_rad, o_code_phase_step_chips, o_phase_step_rate_rad;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, o_busy, o_err;
  logic [EPOCH_W-1:0] o_epoch;

  trk_corr_sequencer_gps_l1 #(.DW(DW), .DROP_CYC(DROP_CYC), .EPOCH_W(EPOCH_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn), .i_start(i_start), .i_stop(i_stop),
    .i_num_epochs(i_num_epochs), .i_prm_wr(i_prm_wr), .i_prm_addr(i_prm_addr), .i_prm_data(i_prm_data),
    .i_prm_commit(i_prm_commit), .o_drop_samples(o_drop_samples), .o_drop_samples_valid(o_drop_samples_valid),
    .o_go(o_go), .o_start_tracking_valid(o_start_tracking_valid), .o_clear_accum(o_clear_accum),
    .o_stop_tracking(o_stop_tracking), .o_stop_tracking_valid(o_stop_tracking_valid),
    .o_phase_step_rad(o_phase_step_rad), .o_rem_carr_phase_rad(o_rem_carr_phase_rad),
    .o_code_phase_step_chips(o_code_phase_step_chips), .o_phase_step_rate_rad(o_phase_step_rate_rad),
    .i_corr_ready(i_corr_ready), .i_iE(i_iE), .i_qE(i_qE), .i_iP(i_iP), .i_qP(i_qP), .i_iL(i_iL), .i_qL(i_qL),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .o_epoch(o_epoch), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] acc_word(input int ep, input int k);
    return 32'h0100_0000 * (k + 1) + 32'h10 * ep + 32'h5;
  endfunction

  function automatic logic [DW:0] exp_beat(input int hdr, input int ep, input int k);
    logic [DW-1:0] d;
    d = (k == 0) ? DW'(hdr) : acc_word(ep, k - 1);
    return {d, (k == 6)};
  endfunction

  function automatic logic [DW-1:0] active_of(input logic [1:0] a);
    case (a)
      2'd0:    return o_phase_step_rad;
      2'd1:    return o_rem_carr_phase_rad;
      2'd2:    return o_code_phase_step_chips;
      default: return o_phase_step_rate_rad;
    endcase
  endfunction

  // Correlator model, manual overrides and tready pattern; sole driver of those inputs.
  logic model_en = 0, bp_en = 0, man_rdy = 0, man_trdy = 0, mrdy;
  logic [3:0] bp_pat = 4'b1001;
  int man_ep = 0, model_ep, mcnt, bp_idx, acc_ep;

  initial begin
    mcnt = -1; model_ep = 0; mrdy = 0; bp_idx = 0; acc_ep = 0;
    i_corr_ready = 0; m_axis_tready = 0;
    {i_iE, i_qE, i_iP, i_qP, i_iL, i_qL} = '0;
    forever begin
      @(posedge axis_aclk); #2;
      if (!model_en) begin
        mcnt = -1; model_ep = 0; mrdy = 0;
      end else if (o_go) begin
        mcnt = 0;
      end else if (mcnt >= 0) begin
        mcnt++;
        if (mcnt == 100) mrdy = 1;
        else if (mcnt == 103) begin mrdy = 0; mcnt = -1; model_ep++; end
      end
      i_corr_ready  = model_en ? mrdy : man_rdy;
      m_axis_tready = bp_en ? bp_pat[bp_idx] : man_trdy;
      bp_idx = (bp_idx + 1) % 4;
      acc_ep = model_en ? model_ep : man_ep;
      i_iE = acc_word(acc_ep, 0); i_qE = acc_word(acc_ep, 1); i_iP = acc_word(acc_ep, 2);
      i_qP = acc_word(acc_ep, 3); i_iL = acc_word(acc_ep, 4); i_qL = acc_word(acc_ep, 5);
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  beat_t beat_q[$];
  beat_t stall_beat;
  int cyc = 0, clr_cnt = 0, stop_cnt = 0, go_cnt = 0, last_cnt = 0, drop_hi_cnt = 0, drop_vld_cnt = 0;
  int strobe_viol = 0, stall_cnt = 0, stall_viol = 0, first_tv_cyc = -1, ready_rise_cyc = -1;
  int stop_cyc = 0, go_cyc = 0;
  logic prev_stall = 0, ready_prev = 0;
  logic [DW-1:0] phase_at_clr = '0, phase_at_go2 = '0;

  initial forever begin @(posedge axis_aclk); cyc++; end

  initial forever begin
    @(negedge axis_aclk);
    if (o_go !== o_start_tracking_valid || o_stop_tracking !== o_stop_tracking_valid) strobe_viol++;
    if (o_go) begin go_cnt++; go_cyc = cyc; if (go_cnt == 2) phase_at_go2 = o_phase_step_rad; end
    if (o_clear_accum) begin clr_cnt++; if (clr_cnt == 1) phase_at_clr = o_phase_step_rad; end
    if (o_stop_tracking) begin stop_cnt++; stop_cyc = cyc; end
    if (o_drop_samples) drop_hi_cnt++;
    if (o_drop_samples_valid) drop_vld_cnt++;
    if (i_corr_ready && !ready_prev && ready_rise_cyc < 0) ready_rise_cyc = cyc;
    ready_prev = i_corr_ready;
    if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
    if (prev_stall && !o_stop_tracking &&
        (!m_axis_tvalid || m_axis_tdata !== stall_beat.data || m_axis_tlast !== stall_beat.last)) stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    if (prev_stall) begin stall_beat = {m_axis_tdata, m_axis_tlast}; stall_cnt++; end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back({m_axis_tdata, m_axis_tlast});
      if (m_axis_tlast) last_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge axis_aclk); #1 i_start = 1;
    @(posedge axis_aclk); #1 i_start = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_busy && n < budget) begin @(negedge axis_aclk); n++; end
    check(name, o_busy, 0);
  endtask

  task automatic wait_go(input int g0, input string name);
    int n = 0;
    while (go_cnt == g0 && n < 300) begin @(negedge axis_aclk); n++; end
    check(name, go_cnt > g0, 1);
  endtask

  typedef struct { logic [1:0] addr; logic [DW-1:0] data; logic [DW-1:0] exp; } prm_vec_t;
  prm_vec_t pv[5];

  initial begin
    int b0, s0, c0, g0, l0, st0, n;
    pv[0] = '{2'd0, 32'hAAAA_0001, 32'h0000_5A5A};
    pv[1] = '{2'd1, 32'h1111_2222, 32'h1111_2222};
    pv[2] = '{2'd2, 32'h0333_0000, 32'h0333_0000};
    pv[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    pv[4] = '{2'd0, 32'h0000_5A5A, 32'h0000_5A5A};

    // Reset state
    repeat (3) @(negedge axis_aclk);
    check("rst_busy", o_busy, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_epoch", o_epoch, 0);
    check("rst_err", o_err, 0);
    check("rst_phase", o_phase_step_rad, 0);
    check("rst_drop", o_drop_samples, 0);
    @(posedge axis_aclk); #1 axis_aresetn = 1;

    // Shadow writes from the table; active copies only at start
    foreach (pv[i]) begin
      @(posedge axis_aclk); #1 i_prm_wr = 1; i_prm_addr = pv[i].addr; i_prm_data = pv[i].data;
    end
    @(posedge axis_aclk); #1 i_prm_wr = 0;
    @(negedge axis_aclk);
    check("shadow_not_active", o_phase_step_rad, 0);

    // Nominal: 3 epochs, model ready 100 cycles after go, tready high
    man_trdy = 1; model_en = 1; i_num_epochs = 3;
    pulse_start();
    @(negedge axis_aclk);
    foreach (pv[i]) check($sformatf("prm_active_%0d", i), active_of(pv[i].addr), pv[i].exp);
    repeat (30) @(posedge axis_aclk);
    #1 i_prm_wr = 1; i_prm_addr = 2'd0; i_prm_data = 32'h0000_1234;
    @(posedge axis_aclk); #1 i_prm_wr = 0; i_prm_commit = 1;
    @(posedge axis_aclk); #1 i_prm_commit = 0;
    @(negedge axis_aclk);
    check("commit_not_yet", o_phase_step_rad, 32'h0000_5A5A);
    wait_idle(2000, "nom_idle_timeout");
    check("nom_beats", beat_q.size(), 21);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 7; k++)
        if (p * 7 + k < beat_q.size())
          check($sformatf("nom_beat_p%0d_k%0d", p, k), beat_q[p * 7 + k], exp_beat(p, p, k));
    check("nom_clears", clr_cnt, 2);
    check("nom_stops", stop_cnt, 1);
    check("nom_gos", go_cnt, 3);
    check("nom_epoch", o_epoch, 3);
    check("nom_err", o_err, 0);
    check("drop_len", drop_hi_cnt, DROP_CYC);
    check("drop_valid_pulses", drop_vld_cnt, 1);
    check("latch_latency", first_tv_cyc - ready_rise_cyc, 2);
    check("phase_at_clr", phase_at_clr, 32'h0000_5A5A);
    check("phase_at_go2", phase_at_go2, 32'h0000_1234);
    check("phase_end", o_phase_step_rad, 32'h0000_1234);
    repeat (5) @(posedge axis_aclk);
    #1 model_en = 0;

    // Stale ready level plus 1-0-0-1 backpressure, single epoch
    man_rdy = 1; man_ep = 7; bp_en = 1; i_num_epochs = 1;
    b0 = beat_q.size(); s0 = stop_cnt; c0 = clr_cnt; g0 = go_cnt; st0 = stall_cnt;
    repeat (2) @(posedge axis_aclk);
    pulse_start();
    wait_go(g0, "stale_go_timeout");
    repeat (30) @(negedge axis_aclk);
    check("stale_no_beats", beat_q.size(), b0);
    check("stale_busy", o_busy, 1);
    check("stale_tvalid", m_axis_tvalid, 0);
    pulse_start();
    @(negedge axis_aclk);
    check("start_ignored_drop", o_drop_samples, 0);
    check("start_ignored_busy", o_busy, 1);
    @(posedge axis_aclk); #1 man_rdy = 0;
    repeat (3) @(posedge axis_aclk);
    #1 man_rdy = 1;
    wait_idle(300, "stale_idle_timeout");
    check("stale_beats", beat_q.size(), b0 + 7);
    for (int k = 0; k < 7; k++)
      if (b0 + k < beat_q.size())
        check($sformatf("bp_beat_%0d", k), beat_q[b0 + k], exp_beat(0, 7, k));
    check("stale_stop", stop_cnt, s0 + 1);
    check("stale_no_clear", clr_cnt, c0);
    check("stale_epoch", o_epoch, 1);
    check("bp_stalled", stall_cnt > st0, 1);
    check("bp_stable", stall_viol, 0);

    // Stop mid-stream with tready low after three beats
    bp_en = 0; man_trdy = 0; man_rdy = 0; i_num_epochs = 0;
    @(posedge axis_aclk); #1 model_en = 1;
    l0 = last_cnt; s0 = stop_cnt;
    pulse_start();
    n = 0;
    while (!m_axis_tvalid && n < 400) begin @(negedge axis_aclk); n++; end
    check("stop_tvalid_timeout", m_axis_tvalid, 1);
    b0 = beat_q.size();
    @(posedge axis_aclk); #1 man_trdy = 1;
    repeat (3) @(posedge axis_aclk);
    #1 man_trdy = 0;
    repeat (2) @(posedge axis_aclk);
    #1 i_stop = 1;
    @(posedge axis_aclk); #1 i_stop = 0;
    @(negedge axis_aclk);
    check("stop_pulse", o_stop_tracking, 1);
    check("stop_valid", o_stop_tracking_valid, 1);
    check("stop_tvalid_drop", m_axis_tvalid, 0);
    check("stop_no_tlast", m_axis_tlast, 0);
    check("stop_err", o_err, 1);
    @(negedge axis_aclk);
    check("stop_idle", o_busy, 0);
    check("stop_pulse_count", stop_cnt, s0 + 1);
    check("stop_beats", beat_q.size(), b0 + 3);
    for (int k = 0; k < 3; k++)
      if (b0 + k < beat_q.size())
        check($sformatf("stop_beat_%0d", k), beat_q[b0 + k], exp_beat(0, 0, k));
    check("stop_last_count", last_cnt, l0);
    #1 model_en = 0;

`ifdef TRK_SEQ_TIMEOUT_EN
    // Watchdog: ready never rises
    man_rdy = 0; i_num_epochs = 0; g0 = go_cnt; s0 = stop_cnt;
    repeat (2) @(posedge axis_aclk);
    pulse_start();
    wait_go(g0, "to_go_timeout");
    n = 0;
    while (stop_cnt == s0 && n < 200) begin @(negedge axis_aclk); n++; end
    check("to_stop_seen", stop_cnt, s0 + 1);
    check("to_delay", stop_cyc - (go_cyc + 1), TIMEOUT_CYC + 1);
    check("to_err", o_err, 1);
    wait_idle(10, "to_idle_timeout");
`endif

    check("strobe_valid_pairs", strobe_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/trk_corr_sequencer_gps_l1.md
Name: trk_corr_sequencer_gps_l1

Overview:
- Control-side counterpart of the GPS L1 tracking correlator: drives its drop/go/clear/stop handshake and consumes its ready plus six E/P/L I/Q accumulators.
- Serialises each epoch's results onto an AXI-Stream master for the tracking-loop processor.
- Double-buffers per-epoch NCO and code parameters so that updates take effect only on an epoch boundary.

Parameters:
- DW, 32, accumulator and parameter word width.
- DROP_CYC, 16, cycles o_drop_samples is held high at start.
- EPOCH_W, 16, width of the epoch counter.
- TIMEOUT_CYC, 2000000, watchdog limit in cycles; used only with TRK_SEQ_TIMEOUT_EN.

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  asynchronous, active-low reset
- i_start  in  1  pulse: begin tracking
- i_stop  in  1  pulse: abort tracking
- i_num_epochs  in  EPOCH_W  epoch count; 0 = run until stopped
- i_prm_wr  in  1  shadow parameter write strobe
- i_prm_addr  in  2  0=phase_step_rad, 1=rem_carr_phase_rad, 2=code_phase_step_chips, 3=phase_step_rate_rad
- i_prm_data  in  DW  shadow parameter write data
- i_prm_commit  in  1  mark the shadow set pending for the next boundary
- o_drop_samples, o_drop_samples_valid  out  1  to correlator
- o_go, o_start_tracking_valid  out  1  to correlator
- o_clear_accum  out  1  to correlator
- o_stop_tracking, o_stop_tracking_valid  out  1  to correlator
- o_phase_step_rad, o_rem_carr_phase_rad, o_code_phase_step_chips, o_phase_step_rate_rad  out  DW each  active parameter registers
- i_corr_ready  in  1  correlator result-ready level
- i_iE, i_qE, i_iP, i_qP, i_iL, i_qL  in  DW each  correlator accumulators
- m_axis_tdata  out  DW  result stream data
- m_axis_tvalid  out  1  result stream valid
- m_axis_tready  in  1  result stream ready
- m_axis_tlast  out  1  result stream last word
- o_epoch  out  EPOCH_W  completed-epoch count
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  sticky error flag

Behaviour:
- Reset: asynchronous on axis_aresetn low.
  - All outputs reset to 0, o_epoch=0, state=IDLE, pending-commit flag=0.
  - Active and shadow registers reset to 0.
- All strobes (go, clear, stop and their valids) are exactly one-cycle pulses, with valid coincident with its strobe.
- States:
  - IDLE: on i_start, load active registers from shadow, clear o_epoch and o_err, go to DROP.
  - DROP: o_drop_samples=1 and o_drop_samples_valid=1 on the first cycle only; held DROP_CYC cycles, then go to REL.
  - REL: o_drop_samples=0 for one cycle, then go to GO.
  - GO: pulse o_go and o_start_tracking_valid, then go to WAIT.
  - WAIT: wait for a rising edge of i_corr_ready (registered previous value, edge = now 1 and previous 0).
    - A level already high on entry must not trigger.
    - On the edge, latch the six accumulators in one cycle and go to SEND.
  - SEND: 7 beats, in this order: {EPOCH_W-bit epoch zero-extended to DW}, iE, qE, iP, qP, iL, qL.
    - tlast is on beat 7.
    - tdata/tvalid are stable until tready is seen; a beat transfers on tvalid&tready.
    - After the final beat, o_epoch increments (wraps modulo 2^EPOCH_W).
    - If i_num_epochs!=0 and o_epoch==i_num_epochs, go to STOP; otherwise go to CLR.
  - CLR: pulse o_clear_accum.
    - If the commit flag is set, copy shadow to active in the same cycle and clear the flag.
    - Then go to GO.
  - STOP: pulse o_stop_tracking and o_stop_tracking_valid, then go to IDLE.
- i_stop in any non-IDLE state goes to STOP on the next cycle.
  - An in-flight stream packet is abandoned: tvalid drops and no tlast is sent.
  - o_err sets if a beat was pending when the stop occurred.
- i_prm_wr with i_prm_commit in the same cycle: the write lands first, then commit.
- A commit arriving in the same cycle as CLR applies on the following boundary.
- Result latency: 1 cycle from the ready edge to the latch; first beat valid 1 cycle after the latch.
- i_start while busy is ignored.

Optional Feature:
- Macro: TRK_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT.
  - Reaching TIMEOUT_CYC sets o_err and goes to STOP.
  - The counter clears on every entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; o_err is set only by an abandoned stream packet.

Decomposition:
- Package trk_seq_pkg:
  - state encoding enum;
  - parameter-address constants PRM_PHASE_STEP=0, PRM_REM_PHASE=1, PRM_CODE_STEP=2, PRM_PHASE_RATE=3;
  - STREAM_BEATS=7.
- One sub-module, trk_seq_result_ser:
  - latches the 7 words and runs the AXI-Stream beat counter and tlast;
  - takes load/abort in, returns done.

Test Plan:
- Nominal: i_num_epochs=3, correlator model raises ready 100 cycles after each go, tready=1.
  - Expect 3 packets of 7 beats with header words 0,1,2.
  - Expect exactly 2 clear pulses, then a stop pulse; o_epoch=3; o_busy low.
- Stale ready: i_corr_ready already high on WAIT entry, never toggled.
  - No capture and no stream output until ready falls and rises again.
- Backpressure: tready toggling 1-0-0-1.
  - Beats 0..6 arrive in order with data unchanged while stalled; tlast only on beat 7.
- Parameter commit: write phase_step_rad=0x1234 during epoch 0, then commit.
  - Active output stays at its old value until the CLR cycle and equals 0x1234 from the following go onward.
- Stop mid-stream: i_stop after beat 3 with tready=0.
  - tvalid drops, no tlast, stop pulse issued, o_err=1, state returns to IDLE.
- Timeout (TRK_SEQ_TIMEOUT_EN, TIMEOUT_CYC=50): ready never asserts.
  - o_err=1 and stop pulse 51 cycles after WAIT entry.
